// File: rtl/program_loader.sv
// program_loader: streams a source into instruction/data RAMs, then releases the core from reset
module program_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] im_words,
  input  logic [11:0] dm_words,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic        im_cen,
  output logic        im_wen,
  output logic        im_oen,
  output logic [10:0] im_addr,
  output logic [31:0] im_datain,
  output logic        dm_cen,
  output logic        dm_wen,
  output logic        dm_oen,
  output logic [10:0] dm_addr,
  output logic [31:0] dm_datain,
  output logic        loading,
  output logic        core_rst_n,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, LOAD_IM, LOAD_DM, RELEASE, RUN} state_t;
  state_t state;
  logic [11:0] im_eff, dm_eff, im_cnt, dm_cnt, cnt;
  logic last, im_wr, dm_wr;
  assign im_eff = im_words > 12'd2048 ? 12'd2048 : im_words;
  assign dm_eff = dm_words > 12'd2048 ? 12'd2048 : dm_words;
  assign last = cnt == (state == LOAD_IM ? im_cnt : dm_cnt) - 12'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      im_cnt <= '0;
      dm_cnt <= '0;
      done <= 1'b0;
    end else begin
      done <= state == RELEASE;
      case (state)
        IDLE, RUN: if (start) begin
          im_cnt <= im_eff;
          dm_cnt <= dm_eff;
          cnt <= '0;
          state <= im_eff != 0 ? LOAD_IM : dm_eff != 0 ? LOAD_DM : RELEASE;
        end
        LOAD_IM: if (s_valid) begin
          cnt <= last ? 12'd0 : cnt + 12'd1;
          if (last) state <= dm_cnt != 0 ? LOAD_DM : RELEASE;
        end
        LOAD_DM: if (s_valid) begin
          cnt <= last ? 12'd0 : cnt + 12'd1;
          if (last) state <= RELEASE;
        end
        RELEASE: state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end
  // a reset cycle never writes, even when the old state was a load state
  assign im_wr = state == LOAD_IM && s_valid && !rst;
  assign dm_wr = state == LOAD_DM && s_valid && !rst;
  assign s_ready = state == LOAD_IM || state == LOAD_DM;
  assign busy = s_ready || state == RELEASE;
  assign core_rst_n = state == RUN;
  assign loading = state != RUN;
  assign im_cen = !im_wr;
  assign im_wen = !im_wr;
  assign im_oen = 1'b1;
  assign im_addr = im_wr ? cnt[10:0] : 11'd0;
  assign im_datain = im_wr ? s_data : 32'd0;
  assign dm_cen = !dm_wr;
  assign dm_wen = !dm_wr;
  assign dm_oen = 1'b1;
  assign dm_addr = dm_wr ? cnt[10:0] : 11'd0;
  assign dm_datain = dm_wr ? s_data : 32'd0;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed sessions with a scoreboard of expected RAM writes
module tb_program_loader;
  logic clk = 0, rst = 1, start = 0, s_valid = 0;
  logic [11:0] im_words = 0, dm_words = 0;
  logic [31:0] s_data = 0;
  logic s_ready, im_cen, im_wen, im_oen, dm_cen, dm_wen, dm_oen;
  logic loading, core_rst_n, busy, done;
  logic [10:0] im_addr, dm_addr;
  logic [31:0] im_datain, dm_datain;
  typedef struct packed {logic dm; logic [10:0] a; logic [31:0] d;} wr_t;
  wr_t q[$];
  int total = 0, bad = 0;
  program_loader dut (.clk(clk), .rst(rst), .start(start), .im_words(im_words), .dm_words(dm_words),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .im_cen(im_cen), .im_wen(im_wen),
    .im_oen(im_oen), .im_addr(im_addr), .im_datain(im_datain), .dm_cen(dm_cen), .dm_wen(dm_wen),
    .dm_oen(dm_oen), .dm_addr(dm_addr), .dm_datain(dm_datain), .loading(loading),
    .core_rst_n(core_rst_n), .busy(busy), .done(done));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic word(input logic dm, input logic [10:0] a, input logic [31:0] d);
    s_valid = 1;
    s_data = d;
    q.push_back('{dm, a, d});
  endtask
  // status outputs as {loading, core_rst_n, busy, done, s_ready}
  task automatic status(input string tag, input logic [4:0] exp);
    @(negedge clk);
    chk(tag, {loading, core_rst_n, busy, done, s_ready}, exp);
  endtask
  always @(negedge clk) begin
    chk("oen", {im_oen, dm_oen}, 2'b11);
    if (im_cen === 1'b0 || dm_cen === 1'b0) begin
      if (q.size() == 0) chk("unexpected_write", {im_cen, dm_cen}, 2'b11);
      else begin
        wr_t e;
        e = q.pop_front();
        chk("wr_port", {im_cen, dm_cen}, e.dm ? 2'b10 : 2'b01);
        chk("wr_wen", {im_wen, dm_wen}, e.dm ? 2'b10 : 2'b01);
        chk("wr_addr", e.dm ? dm_addr : im_addr, e.a);
        chk("wr_data", e.dm ? dm_datain : im_datain, e.d);
      end
    end else chk("idle_ram", {im_wen, dm_wen, im_addr, dm_addr, im_datain, dm_datain}, {2'b11, 86'd0});
  end
  initial begin
    tick(); tick();
    status("reset", 5'b10000);
    rst = 0;
    tick();
    // session 1: 3 IM + 2 DM words with valid held high
    start = 1; im_words = 3; dm_words = 2; s_valid = 1; s_data = 32'hA0;
    status("s1_idle", 5'b10000);
    tick();
    start = 0; im_words = 0; dm_words = 0;
    for (int i = 0; i < 5; i++) begin
      word(i >= 3, i >= 3 ? 11'(i - 3) : 11'(i), 32'hA0 + i);
      status("s1_load", 5'b10101);
      tick();
    end
    s_data = 32'hEE;
    status("s1_release", 5'b10100);
    tick();
    status("s1_run_done", 5'b01010);
    s_valid = 0;
    tick();
    status("s1_run", 5'b01000);
    chk("s1_drained", q.size(), 0);
    // session 2: 2 IM words, valid 1,0,0,1
    start = 1; im_words = 2; dm_words = 0;
    tick();
    start = 0;
    status("s2_reload", 5'b10101);
    word(0, 0, 32'h11); tick();
    s_valid = 0; tick(); tick();
    word(0, 1, 32'h22); tick();
    s_valid = 0;
    status("s2_release", 5'b10100);
    tick();
    status("s2_run_done", 5'b01010);
    // session 3: empty session goes straight to RELEASE
    start = 1; im_words = 0; dm_words = 0; s_valid = 1;
    tick();
    start = 0;
    status("s3_release", 5'b10100);
    tick();
    status("s3_run_done", 5'b01010);
    // session 4: oversized IM count saturates at 2048
    start = 1; im_words = 12'd4095;
    tick();
    start = 0;
    for (int i = 0; i < 2048; i++) begin
      word(0, 11'(i), $urandom);
      tick();
    end
    s_data = 32'h55;
    status("s4_release", 5'b10100);
    tick();
    status("s4_run_done", 5'b01010);
    start = 1; im_words = 1; s_valid = 0;
    tick();
    start = 0;
    status("s4_reload", 5'b10101);
    word(0, 0, 32'h77); tick();
    s_valid = 0; tick();
    status("s4_run2", 5'b01010);
    // session 5: reset after 2 of 5 words
    start = 1; im_words = 5;
    tick();
    start = 0;
    word(0, 0, 32'h31); tick();
    word(0, 1, 32'h32); tick();
    rst = 1; s_data = 32'h33;
    @(negedge clk);
    chk("s5_rst_cycle_cen", im_cen, 1'b1);
    tick();
    rst = 0; s_valid = 0;
    status("s5_idle", 5'b10000);
    start = 1; im_words = 1; dm_words = 1;
    tick();
    start = 0;
    word(0, 0, 32'h41); tick();
    word(1, 0, 32'h42); tick();
    s_valid = 0;
    status("s5_release", 5'b10100);
    tick();
    status("s5_run_done", 5'b01010);
    // session 6: start during LOAD_DM is ignored
    start = 1; im_words = 1; dm_words = 3;
    tick();
    start = 0;
    word(0, 0, 32'h51); tick();
    word(1, 0, 32'h52); tick();
    start = 1; im_words = 0; dm_words = 0;
    word(1, 1, 32'h53);
    status("s6_dm_start", 5'b10101);
    tick();
    start = 0;
    word(1, 2, 32'h54); tick();
    s_valid = 0;
    status("s6_release", 5'b10100);
    tick();
    status("s6_run_done", 5'b01010);
    tick();
    chk("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
